// File: rtl/ktms_mmrd_mc_arb.sv
// rtl/ktms_mmrd_mc_arb.sv - round-robin arbiter sharing one context register-file read port among nreq MMIO read decoders
// Optional context parity checker: define KTMS_MMRD_ARB_PARCHK_EN.
module ktms_mmrd_mc_arb #(
    parameter int nreq          = 4,
    parameter int nreq_width    = 2,
    parameter int ctxtid_width  = 10,
    parameter int lcladdr_width = 1,
    parameter int lat           = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [nreq-1:0]                 i_req_v,
    output logic [nreq-1:0]                 o_req_r,
    input  logic [nreq*ctxtid_width-1:0]    i_req_ctxt,
    input  logic [nreq*lcladdr_width-1:0]   i_req_addr,
    input  logic                            i_hold,
    output logic                            o_rd_v,
    output logic [ctxtid_width-1:0]         o_rd_ctxt,
    output logic [lcladdr_width-1:0]        o_rd_addr,
    input  logic                            i_rd_v,
    input  logic [63:0]                     i_rd_d,
    output logic [nreq-1:0]                 o_rsp_v,
    output logic [63:0]                     o_rsp_d,
    output logic [1:0]                      o_err,
    output logic                            o_idle
);

    logic [nreq_width-1:0]    ptr_q, ptr_d;
    logic [nreq-1:0]          gnt;
    logic [nreq_width-1:0]    gidx;
    logic                     gvld;
    logic [nreq_width-1:0]    cand;
    logic                     acc;
    logic [ctxtid_width-1:0]  sel_ctxt;
    logic [lcladdr_width-1:0] sel_addr;

    // Stage 0 of the tag pipeline doubles as the issue strobe; stage lat meets the returning data.
    logic [lat:0]             tag_v_q, tag_v_d;
    logic [nreq_width-1:0]    tag_idx_q [lat+1];
    logic [ctxtid_width-1:0]  rd_ctxt_q;
    logic [lcladdr_width-1:0] rd_addr_q;
    logic [nreq-1:0]          rsp_v_q, rsp_v_d;
    logic [63:0]              rsp_d_q;
    logic [1:0]               err_q, err_d;
    logic                     tail_v;
    logic [nreq_width-1:0]    tail_idx;
    logic                     hit;
    logic                     proto_err;
    logic                     par_err;

    always_comb begin
        gnt  = '0;
        gidx = '0;
        gvld = 1'b0;
        cand = '0;
        if (!i_hold) begin
            for (int k = 1; k <= nreq; k++) begin
                cand = nreq_width'((int'(ptr_q) + k) % nreq);
                if (!gvld && i_req_v[cand]) begin
                    gvld = 1'b1;
                    gidx = cand;
                end
            end
        end
        if (gvld) gnt[gidx] = 1'b1;
    end

    assign acc     = |(i_req_v & gnt);
    assign o_req_r = gnt;
    assign ptr_d   = acc ? gidx : ptr_q;

    // Requester 0 occupies the MSBs of the packed request buses.
    always_comb begin
        sel_ctxt = '0;
        sel_addr = '0;
        for (int i = 0; i < nreq; i++) begin
            if (gidx == nreq_width'(i)) begin
                sel_ctxt = i_req_ctxt[(nreq-1-i)*ctxtid_width +: ctxtid_width];
                sel_addr = i_req_addr[(nreq-1-i)*lcladdr_width +: lcladdr_width];
            end
        end
    end

    assign tail_v    = tag_v_q[lat];
    assign tail_idx  = tag_idx_q[lat];
    assign hit       = tail_v & i_rd_v;
    assign proto_err = tail_v ^ i_rd_v;
    assign tag_v_d   = {tag_v_q[lat-1:0], acc};

`ifdef KTMS_MMRD_ARB_PARCHK_EN
    assign par_err = tag_v_q[0] & ~(^rd_ctxt_q);
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        rsp_v_d = '0;
        if (hit) rsp_v_d[tail_idx] = 1'b1;
        err_d = err_q | {par_err, proto_err};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= nreq_width'(nreq - 1);
            tag_v_q <= '0;
            rsp_v_q <= '0;
            err_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            tag_v_q <= tag_v_d;
            rsp_v_q <= rsp_v_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            rd_ctxt_q <= sel_ctxt;
            rd_addr_q <= sel_addr;
        end
        tag_idx_q[0] <= gidx;
        for (int s = 1; s <= lat; s++) tag_idx_q[s] <= tag_idx_q[s-1];
        if (hit) rsp_d_q <= i_rd_d;
    end

    assign o_rd_v    = tag_v_q[0];
    assign o_rd_ctxt = rd_ctxt_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rsp_v   = rsp_v_q;
    assign o_rsp_d   = rsp_d_q;
    assign o_err     = err_q;
    assign o_idle    = ~|tag_v_q;

endmodule
